// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: FSM states, boot PC,
// canonical NOP encoding and the sequential PC stride.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam int          PC_INC           = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, insn} pairs with a combinational head and a
// single-cycle flush; asynchronous active-low reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [AWIDTH-1:0]        push_pc,
  input  logic [DWIDTH-1:0]        push_insn,
  output logic                     head_valid,
  output logic [AWIDTH-1:0]        head_pc,
  output logic [DWIDTH-1:0]        head_insn,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr_reg]   <= push_pc;
      insn_mem[wr_ptr_reg] <= push_insn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is never reset, so the head is masked to zero while empty.
  assign head_valid = (count_reg != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign head_insn  = head_valid ? insn_mem[rd_ptr_reg] : '0;
  assign count      = count_reg;

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    (do_push && (count_reg == (PW+1)'(DEPTH))) |-> do_pop);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, an
// in-order response queue to decode, and redirect with stale-response drop.
// Optional FETCH_QUEUE_PERF_EN adds stall and flushed-response counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                AWIDTH          = 32,
  parameter int                DWIDTH          = 32,
  parameter int                DEPTH           = 4,
  parameter logic [AWIDTH-1:0] RESET_PC        = AWIDTH'(RESET_PC_DEFAULT),
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [AWIDTH-1:0]      redirect_pc_i,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [AWIDTH-1:0]      imem_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [DWIDTH-1:0]      imem_rsp_data_i,
  output logic                   dec_valid_o,
  input  logic                   dec_ready_i,
  output logic [AWIDTH-1:0]      pc_o,
  output logic [DWIDTH-1:0]      insn_o,
  output logic [$clog2(DEPTH):0] occupancy_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]            stall_cycles_o,
  output logic [31:0]            flushed_rsp_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + OW;
  localparam logic [OW-1:0]     OUT_ONE    = 1;
  localparam logic [AWIDTH-1:0] PC_STEP    = AWIDTH'(PC_INC);
  localparam logic [AWIDTH-1:0] ALIGN_MASK = ~AWIDTH'(3);

  fetch_state_t      state_reg;
  logic [AWIDTH-1:0] fetch_pc_reg;
  logic [AWIDTH-1:0] resp_pc_reg;
  logic [OW-1:0]     outstanding_reg;
  logic [OW-1:0]     outstanding_next;
  logic [OW-1:0]     drop_cnt_reg;
  logic [SW-1:0]     credit_sum;
  logic [AWIDTH-1:0] redirect_target;
  logic              req_fire;
  logic              rsp_push;
  logic              fifo_pop;

  // Queued plus in-flight entries never exceed DEPTH, so a response always has a slot.
  assign credit_sum       = SW'(occupancy_o) + SW'(outstanding_reg);
  assign imem_req_valid_o = (state_reg == RUN) && (credit_sum < SW'(DEPTH))
                            && (outstanding_reg < OW'(MAX_OUTSTANDING));
  assign imem_addr_o      = fetch_pc_reg;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_push         = (state_reg == RUN) && imem_rsp_valid_i && !redirect_i;
  assign fifo_pop         = dec_valid_o && dec_ready_i;
  assign redirect_target  = redirect_pc_i & ALIGN_MASK;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (req_fire && !imem_rsp_valid_i)
      outstanding_next = outstanding_reg + OUT_ONE;
    else if (!req_fire && imem_rsp_valid_i)
      outstanding_next = outstanding_reg - OUT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (redirect_i) begin
        // Everything still in flight, including a request accepted this cycle, is stale.
        fetch_pc_reg <= redirect_target;
        resp_pc_reg  <= redirect_target;
        drop_cnt_reg <= outstanding_next;
        state_reg    <= (outstanding_next != '0) ? FLUSH : RUN;
      end else begin
        case (state_reg)
          BOOT: state_reg <= RUN;
          RUN: begin
            if (req_fire)         fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            if (imem_rsp_valid_i) resp_pc_reg  <= resp_pc_reg + PC_STEP;
          end
          FLUSH: begin
            if (imem_rsp_valid_i) drop_cnt_reg <= drop_cnt_reg - OUT_ONE;
            if ((drop_cnt_reg == '0) || (imem_rsp_valid_i && (drop_cnt_reg == OUT_ONE)))
              state_reg <= RUN;
          end
          default: state_reg <= BOOT;
        endcase
      end
    end
  end

  fetch_fifo #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_push),
    .pop        (fifo_pop),
    .flush      (redirect_i),
    .push_pc    (resp_pc_reg),
    .push_insn  (imem_rsp_data_i),
    .head_valid (dec_valid_o),
    .head_pc    (pc_o),
    .head_insn  (insn_o),
    .count      (occupancy_o)
  );

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flushed_cnt_reg;
  logic        rsp_discard;

  assign rsp_discard = imem_rsp_valid_i && (redirect_i || (state_reg == FLUSH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg   <= '0;
      flushed_cnt_reg <= '0;
    end else begin
      if (dec_ready_i && !dec_valid_o && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (rsp_discard && (flushed_cnt_reg != '1))
        flushed_cnt_reg <= flushed_cnt_reg + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_reg;
  assign flushed_rsp_o  = flushed_cnt_reg;
`endif

  rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid_i |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a 1-cycle imem model tags requests by
// redirect epoch and a scoreboard holds the pc/insn pairs decode must see.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 3;
  localparam logic [31:0] BOOT_PC  = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [2:0]  occupancy_o;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flushed_rsp_o;
`endif

  fetch_queue #(
    .AWIDTH          (32),
    .DWIDTH          (32),
    .DEPTH           (DEPTH),
    .RESET_PC        (BOOT_PC),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .pc_o             (pc_o),
    .insn_o           (insn_o),
    .occupancy_o      (occupancy_o)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_cycles_o   (stall_cycles_o),
    .flushed_rsp_o    (flushed_rsp_o)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_ep_q[$];
  pair_t       exp_q[$];
  int          epoch = 0;
  logic        mem_en = 1'b0;
  logic [31:0] exp_fetch = BOOT_PC;
  int          n_deliv = 0;
  int          n_drop = 0;
  int          stall_model = 0;
  logic [31:0] last_pc = '0;
  logic        st_rq = 1'b0;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic reset_models();
    mem_addr_q.delete();
    mem_ep_q.delete();
    exp_q.delete();
    epoch++;
    exp_fetch   = BOOT_PC;
    n_drop      = 0;
    stall_model = 0;
  endtask

  // One clock: called at a negedge with inputs set, returns at the next negedge.
  task automatic step();
    pair_t       p;
    logic [31:0] a;
    int          e;
    if (mem_en && mem_addr_q.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = insn_of(mem_addr_q[0]);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    st_rq = imem_req_valid_o && imem_req_ready_i;
    if (dec_ready_i && !dec_valid_o) stall_model++;
    if (dec_valid_o && dec_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL deliver_unexpected: pc=%h insn=%h required=no delivery", pc_o, insn_o);
      end else begin
        p = exp_q.pop_front();
        if (pc_o !== p.pc || insn_o !== p.insn) begin
          failures++;
          $display("FAIL deliver: pc=%h insn=%h required pc=%h insn=%h", pc_o, insn_o, p.pc, p.insn);
        end
      end
      n_deliv++;
      last_pc = pc_o;
    end
    if (imem_rsp_valid_i) begin
      a = mem_addr_q.pop_front();
      e = mem_ep_q.pop_front();
      if (e == epoch && !redirect_i) begin
        p.pc   = a;
        p.insn = insn_of(a);
        exp_q.push_back(p);
      end else begin
        n_drop++;
      end
    end
    if (st_rq) begin
      checks++;
      if (imem_addr_o !== exp_fetch) begin
        failures++;
        $display("FAIL req_addr: addr=%h required=%h", imem_addr_o, exp_fetch);
      end
      exp_fetch += 32'd4;
      mem_addr_q.push_back(imem_addr_o);
      mem_ep_q.push_back(epoch);
    end
    if (redirect_i) begin
      exp_q.delete();
      epoch++;
      exp_fetch = redirect_pc_i & ~32'h3;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stop accepting requests until every in-flight response has returned.
  task automatic drain();
    imem_req_ready_i = 1'b0;
    mem_en = 1'b1;
    dec_ready_i = 1'b1;
    repeat (5) step();
  endtask

  task automatic wait_first(input logic [31:0] target, input string name);
    int n0;
    n0 = n_deliv;
    for (int i = 0; i < 12 && n_deliv == n0; i++) step();
    checks++;
    if (n_deliv == n0) begin
      failures++;
      $display("FAIL %s: no delivery within 12 cycles, required first pc=%h", name, target);
    end else if (last_pc !== target) begin
      failures++;
      $display("FAIL %s: first pc=%h required=%h", name, last_pc, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req_valid_o, dec_valid_o, pc_o, insn_o, occupancy_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b dv=%b pc=%h insn=%h occ=%0d required all 0",
               imem_req_valid_o, dec_valid_o, pc_o, insn_o, occupancy_o);
    end
    rst = 1'b1;
    reset_models();
    imem_req_ready_i = 1'b1;
    dec_ready_i = 1'b1;
    mem_en = 1'b1;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL boot_idle: req_valid=%b required=0", imem_req_valid_o);
    end
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== BOOT_PC) begin
      failures++;
      $display("FAIL boot_first_req: valid=%b addr=%h required valid=1 addr=%h",
               imem_req_valid_o, imem_addr_o, BOOT_PC);
    end
  endtask

  task automatic test_stream();
    int n0;
    n0 = n_deliv;
    repeat (20) step();
    checks++;
    if (n_deliv - n0 != 18) begin
      failures++;
      $display("FAIL stream_rate: delivered=%0d required=18", n_deliv - n0);
    end
  endtask

  task automatic test_backpressure();
    dec_ready_i = 1'b0;
    repeat (8) step();
    checks++;
    if (occupancy_o !== 3'd4 || imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: occ=%0d req_valid=%b required occ=4 req_valid=0", occupancy_o, imem_req_valid_o);
    end
    dec_ready_i = 1'b1;
    step();
    dec_ready_i = 1'b0;
    checks++;
    if (occupancy_o !== 3'd3 || imem_req_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_one_pop: occ=%0d req_valid=%b required occ=3 req_valid=1", occupancy_o, imem_req_valid_o);
    end
    step();
    checks++;
    if (st_rq !== 1'b1 || imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_req: issued=%b req_valid_after=%b required issued=1 after=0", st_rq, imem_req_valid_o);
    end
    dec_ready_i = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_redirect();
    drain();
    mem_en = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (2) step();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0100_0100;
    step();
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    mem_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dec_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL redir_flush%0d: dv=%b req_valid=%b required 0/0", i, dec_valid_o, imem_req_valid_o);
      end
      step();
    end
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0100_0100) begin
      failures++;
      $display("FAIL redir_next_req: valid=%b addr=%h required valid=1 addr=01000100", imem_req_valid_o, imem_addr_o);
    end
    wait_first(32'h0100_0100, "redir_first_pc");
  endtask

  task automatic test_coincident();
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] f0;
`endif
    drain();
    mem_en = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (2) step();
    mem_en = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0400;
`ifdef FETCH_QUEUE_PERF_EN
    f0 = flushed_rsp_o;
`endif
    checks++;
    if (imem_req_valid_o !== 1'b1 || mem_addr_q.size() != 2) begin
      failures++;
      $display("FAIL coinc_setup: req_valid=%b inflight=%0d required 1/2", imem_req_valid_o, mem_addr_q.size());
    end
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dec_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL coinc_flush%0d: dv=%b req_valid=%b required 0/0", i, dec_valid_o, imem_req_valid_o);
      end
      step();
    end
`ifdef FETCH_QUEUE_PERF_EN
    checks++;
    if (flushed_rsp_o - f0 !== 32'd3) begin
      failures++;
      $display("FAIL coinc_flushed_cnt: delta=%0d required=3", flushed_rsp_o - f0);
    end
`endif
    wait_first(32'h0000_0400, "coinc_first_pc");
  endtask

  task automatic test_back_to_back();
    drain();
    mem_en = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (2) step();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    step();
    mem_en = 1'b1;
    redirect_pc_i = 32'h0000_0303;
    step();
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    checks++;
    if (dec_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_still_flush: dv=%b req_valid=%b required 0/0", dec_valid_o, imem_req_valid_o);
    end
    step();
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0000_0300) begin
      failures++;
      $display("FAIL b2b_next_req: valid=%b addr=%h required valid=1 addr=00000300", imem_req_valid_o, imem_addr_o);
    end
    wait_first(32'h0000_0300, "b2b_first_pc");
    repeat (6) step();
  endtask

  task automatic test_wrap();
    int n0;
    drain();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    step();
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b1;
    n0 = n_deliv;
    repeat (8) step();
    checks++;
    if (n_deliv - n0 != 6 || last_pc !== 32'h0000_000C) begin
      failures++;
      $display("FAIL wrap: delivered=%0d last_pc=%h required 6 / 0000000c", n_deliv - n0, last_pc);
    end
  endtask

  task automatic test_async_reset();
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL areset_req: req_valid=%b required=0", imem_req_valid_o);
    end
    checks++;
    if (dec_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin
      failures++;
      $display("FAIL areset_queue: dv=%b occ=%0d required 0/0", dec_valid_o, occupancy_o);
    end
    checks++;
    if (pc_o !== 32'h0 || insn_o !== 32'h0) begin
      failures++;
      $display("FAIL areset_head: pc=%h insn=%h required 0/0", pc_o, insn_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    reset_models();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0800;
    step();
    redirect_i = 1'b0;
    checks++;
    if (st_rq !== 1'b0 || imem_req_valid_o !== 1'b1 || imem_addr_o !== 32'h0000_0800) begin
      failures++;
      $display("FAIL boot_redirect: boot_req=%b valid=%b addr=%h required 0/1/00000800",
               st_rq, imem_req_valid_o, imem_addr_o);
    end
    repeat (6) step();
    checks++;
    if (last_pc !== 32'h0000_080C) begin
      failures++;
      $display("FAIL boot_redirect_stream: last_pc=%h required=0000080c", last_pc);
    end
`ifdef FETCH_QUEUE_PERF_EN
    checks++;
    if (stall_cycles_o !== 32'(stall_model) || flushed_rsp_o !== 32'(n_drop)) begin
      failures++;
      $display("FAIL perf_counts: stall=%0d flushed=%0d required %0d/%0d",
               stall_cycles_o, flushed_rsp_o, stall_model, n_drop);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_back_to_back();
    test_wrap();
`ifdef FETCH_QUEUE_PERF_EN
    checks++;
    if (stall_cycles_o !== 32'(stall_model) || flushed_rsp_o !== 32'(n_drop)) begin
      failures++;
      $display("FAIL perf_midrun: stall=%0d flushed=%0d required %0d/%0d",
               stall_cycles_o, flushed_rsp_o, stall_model, n_drop);
    end
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
